// File: rtl/router_pkg.sv
// router_pkg: shared types and sizing constants for the router input lanes
package router_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} rx_state_e;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int PAD_CYCLES = 5;
  localparam int NUM_PORTS = 16;
  localparam int MAX_BYTES = 32;
  localparam int ADDR_CW = $clog2(ADDR_W);
  localparam int PAD_CW = $clog2(PAD_CYCLES);
  localparam int BIT_CW = $clog2(DATA_W);
  localparam int BYTE_CW = $clog2(MAX_BYTES) + 1;
  typedef logic [ADDR_W-1:0] da_t;
endpackage

// File: rtl/router_in_shift.sv
// router_in_shift: LSB-first byte assembler with bit counter and full flag
module router_in_shift
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] byte_asm,
  output logic              full
);
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_CW-1:0] cnt_q, cnt_d;
  assign full = cnt_q == BIT_CW'(DATA_W - 1);
  // byte_asm already includes the incoming bit so the completing cycle can emit it directly
  always_comb begin
    byte_asm = shift_q;
    byte_asm[cnt_q] = din;
    shift_d = clr ? '0 : en ? byte_asm : shift_q;
    cnt_d = clr ? '0 : en ? (full ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  // shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/router_in_port.sv
// router_in_port: bit-serial input lane deserializer with address decode and framing checks
module router_in_port
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              frame_n,
  input  logic              valid_n,
  output logic [ADDR_W-1:0] da,
  output logic              da_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              sop,
  output logic              eop,
  output logic              busy,
  output logic              err_proto,
  output logic              err_len
);
  rx_state_e state_q, state_d;
  da_t addr_sr_q, addr_sr_d, da_q, da_d;
  logic [ADDR_CW-1:0] addr_cnt_q, addr_cnt_d;
  logic [PAD_CW-1:0] pad_cnt_q, pad_cnt_d;
  logic [BYTE_CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] byte_data_q, byte_data_d, byte_asm;
  logic first_q, first_d, da_valid_q, da_valid_d, byte_valid_q, byte_valid_d;
  logic sop_q, sop_d, eop_q, eop_d, busy_q, err_proto_q, err_proto_d, err_len_q, err_len_d;
  logic shift_en, full;
  router_in_shift u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != DATA),
    .en      (shift_en),
    .din     (din),
    .byte_asm(byte_asm),
    .full    (full)
  );
  // next state, counters and registered output pulses
  always_comb begin
    state_d = state_q;
    addr_sr_d = addr_sr_q;
    addr_cnt_d = addr_cnt_q;
    pad_cnt_d = pad_cnt_q;
    byte_cnt_d = byte_cnt_q;
    first_d = first_q;
    da_d = da_q;
    byte_data_d = byte_data_q;
    da_valid_d = 1'b0;
    byte_valid_d = 1'b0;
    sop_d = 1'b0;
    eop_d = 1'b0;
    err_proto_d = 1'b0;
    err_len_d = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: if (!frame_n) begin
        addr_sr_d[0] = din;
        addr_cnt_d = 1;
        state_d = ADDR;
      end
      ADDR: if (frame_n) begin
        err_proto_d = 1'b1;
        state_d = IDLE;
      end else begin
        addr_sr_d[addr_cnt_q] = din;
        if (addr_cnt_q == ADDR_CW'(ADDR_W - 1)) begin
          da_d = addr_sr_d;
          da_valid_d = 1'b1;
          pad_cnt_d = '0;
          state_d = PAD;
        end else addr_cnt_d = addr_cnt_q + 1'b1;
      end
      PAD: if (frame_n) begin
        err_proto_d = 1'b1;
        state_d = IDLE;
      end else if (!valid_n) begin
        err_proto_d = 1'b1;
        state_d = DROP;
      end else if (pad_cnt_q == PAD_CW'(PAD_CYCLES - 1)) begin
        byte_cnt_d = '0;
        first_d = 1'b1;
        state_d = DATA;
      end else pad_cnt_d = pad_cnt_q + 1'b1;
      DATA: if (!valid_n) begin
        shift_en = 1'b1;
        if (full && byte_cnt_q == BYTE_CW'(MAX_BYTES)) begin
          err_len_d = 1'b1;
          state_d = frame_n ? IDLE : DROP;
        end else if (full) begin
          byte_valid_d = 1'b1;
          byte_data_d = byte_asm;
          sop_d = first_q;
          eop_d = frame_n;
          first_d = 1'b0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d = frame_n ? IDLE : DATA;
        end else if (frame_n) begin
          err_len_d = 1'b1;
          state_d = IDLE;
        end
      end else if (frame_n) begin
        err_proto_d = 1'b1;
        state_d = IDLE;
      end
      DROP: state_d = frame_n ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
  end
  // state, counters and output registers; reset aborts any frame silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_sr_q <= '0;
      addr_cnt_q <= '0;
      pad_cnt_q <= '0;
      byte_cnt_q <= '0;
      first_q <= 1'b0;
      da_q <= '0;
      byte_data_q <= '0;
      da_valid_q <= 1'b0;
      byte_valid_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      busy_q <= 1'b0;
      err_proto_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_sr_q <= addr_sr_d;
      addr_cnt_q <= addr_cnt_d;
      pad_cnt_q <= pad_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      first_q <= first_d;
      da_q <= da_d;
      byte_data_q <= byte_data_d;
      da_valid_q <= da_valid_d;
      byte_valid_q <= byte_valid_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      busy_q <= state_d != IDLE;
      err_proto_q <= err_proto_d;
      err_len_q <= err_len_d;
    end
  end
  assign da = da_q;
  assign da_valid = da_valid_q;
  assign byte_data = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign sop = sop_q;
  assign eop = eop_q;
  assign busy = busy_q;
  assign err_proto = err_proto_q;
  assign err_len = err_len_q;
endmodule

// File: tb/tb_router_in_port.sv
// tb_router_in_port: directed frames with a scoreboard of expected output events
module tb_router_in_port;
  import router_pkg::*;
  localparam logic [1:0] K_DA = 2'd0, K_BY = 2'd1, K_EP = 2'd2, K_EL = 2'd3;
  typedef struct packed {logic [1:0] k; logic [7:0] d; logic s; logic e;} ev_t;
  logic clk = 0, rst_n = 0, din = 0, frame_n = 1, valid_n = 1;
  logic [ADDR_W-1:0] da;
  logic [DATA_W-1:0] byte_data;
  logic da_valid, byte_valid, sop, eop, busy, err_proto, err_len;
  ev_t exp_q[$];
  int n_vec = 0, n_bad = 0;
  logic [7:0] pay [0:39];
  logic [3:0] a_v;

  always #5 clk = ~clk;

  router_in_port dut (
    .clk(clk), .rst_n(rst_n), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .da(da), .da_valid(da_valid), .byte_data(byte_data), .byte_valid(byte_valid),
    .sop(sop), .eop(eop), .busy(busy), .err_proto(err_proto), .err_len(err_len)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ex(input logic [1:0] k, input logic [7:0] d, input logic s, input logic e);
    exp_q.push_back(ev_t'({k, d, s, e}));
  endtask

  task automatic take(input string nm, input ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s unexpected event: got %0h expected none", nm, act);
    end else begin
      e = exp_q.pop_front();
      chk(nm, 32'(act), 32'(e));
    end
  endtask

  // monitor: every output pulse must match the next queued expectation
  always @(negedge clk) begin
    if (da_valid) take("da", {K_DA, 4'd0, da, 2'b00});
    if (byte_valid) take("byte", {K_BY, byte_data, sop, eop});
    if (err_proto) take("err_proto", {K_EP, 8'd0, 2'b00});
    if (err_len) take("err_len", {K_EL, 8'd0, 2'b00});
    if (!byte_valid && (sop || eop)) begin
      n_vec++;
      n_bad++;
      $display("FAIL stray_marker: got sop=%0b eop=%0b expected 0", sop, eop);
    end
  end

  task automatic cyc(input logic f, input logic v, input logic d);
    frame_n = f;
    valid_n = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0);
  endtask

  task automatic addr_pad(input logic [3:0] a);
    for (int i = 0; i < ADDR_W; i++) cyc(0, 1, a[i]);
    for (int i = 0; i < PAD_CYCLES; i++) cyc(0, 1, 0);
  endtask

  // full frame from pay[]; two bubbles are inserted before payload bit bub_at
  task automatic send_frame(input logic [3:0] a, input int nbits, input int bub_at);
    addr_pad(a);
    for (int k = 0; k < nbits; k++) begin
      if (k == bub_at) begin
        cyc(0, 1, 0);
        cyc(0, 1, 1);
      end
      cyc(k == nbits - 1, 0, pay[k / 8][k % 8]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    chk("reset_outs", {da, da_valid, byte_data, byte_valid, sop, eop, busy, err_proto, err_len}, 0);
    rst_n = 1;
    idle(2);
    // single byte frame: sop and eop together
    pay[0] = 8'hC3;
    ex(K_DA, 8'h0A, 0, 0);
    ex(K_BY, 8'hC3, 1, 1);
    send_frame(4'hA, 8, -1);
    idle(3);
    chk("idle_busy", busy, 0);
    chk("da_hold_A", da, 4'hA);
    // three bytes with bubbles inside byte 2
    pay[0] = 8'h01; pay[1] = 8'hFF; pay[2] = 8'h5A;
    ex(K_DA, 8'h03, 0, 0);
    ex(K_BY, 8'h01, 1, 0);
    ex(K_BY, 8'hFF, 0, 0);
    ex(K_BY, 8'h5A, 0, 1);
    send_frame(4'h3, 24, 10);
    idle(3);
    // back-to-back frames with no gap
    pay[0] = 8'h11;
    ex(K_DA, 8'h01, 0, 0);
    ex(K_BY, 8'h11, 1, 1);
    ex(K_DA, 8'h0F, 0, 0);
    ex(K_BY, 8'hEE, 1, 1);
    send_frame(4'h1, 8, -1);
    pay[0] = 8'hEE;
    send_frame(4'hF, 8, -1);
    idle(3);
    chk("da_hold_F", da, 4'hF);
    // partial final byte
    pay[0] = 8'h1F;
    ex(K_DA, 8'h09, 0, 0);
    ex(K_EL, 8'h00, 0, 0);
    send_frame(4'h9, 5, -1);
    chk("busy_after_short", busy, 0);
    idle(2);
    pay[0] = 8'h96;
    ex(K_DA, 8'h05, 0, 0);
    ex(K_BY, 8'h96, 1, 1);
    send_frame(4'h5, 8, -1);
    idle(3);
    // valid_n during the third pad cycle: drop the rest of the frame
    a_v = 4'h6;
    ex(K_DA, 8'h06, 0, 0);
    ex(K_EP, 8'h00, 0, 0);
    for (int i = 0; i < ADDR_W; i++) cyc(0, 1, a_v[i]);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, i[0]);
    chk("busy_in_drop", busy, 1);
    cyc(1, 0, 1);
    chk("busy_after_drop", busy, 0);
    idle(3);
    // MAX_BYTES + 1 bytes: 32 bytes out, then err_len and no eop
    for (int i = 0; i < 33; i++) pay[i] = 8'(i * 7 + 3);
    ex(K_DA, 8'h02, 0, 0);
    for (int i = 0; i < MAX_BYTES; i++) ex(K_BY, 8'(i * 7 + 3), i == 0, 0);
    ex(K_EL, 8'h00, 0, 0);
    send_frame(4'h2, 33 * 8, -1);
    idle(3);
    // asynchronous reset in the middle of a byte
    a_v = 4'h7;
    ex(K_DA, 8'h07, 0, 0);
    for (int i = 0; i < ADDR_W; i++) cyc(0, 1, a_v[i]);
    for (int i = 0; i < PAD_CYCLES; i++) cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    chk("busy_mid_frame", busy, 1);
    #2;
    rst_n = 0;
    frame_n = 1;
    valid_n = 1;
    #1;
    chk("async_reset_outs", {da, da_valid, byte_data, byte_valid, sop, eop, busy, err_proto, err_len}, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(1);
    pay[0] = 8'h80;
    ex(K_DA, 8'h07, 0, 0);
    ex(K_BY, 8'h80, 1, 1);
    send_frame(4'h7, 8, -1);
    idle(4);
    chk("da_after_reset", da, 4'h7);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/router_in_port.md
Name: router_in_port

Overview:
- Receive-side deserializer for one router input lane; the far end of the bit-serial protocol the bench driver produces on din[i]/frame_n[i]/valid_n[i].
- Decodes the 4-bit destination address, checks the padding phase, and assembles LSB-first payload bits into bytes.
- Presents a byte stream with SOP/EOP markers to the router switching core.
- One instance per input lane (16 in the full router).

Parameters:
- ADDR_W, 4, destination address bits (LSB first).
- PAD_CYCLES, 5, padding cycles between address and payload.
- DATA_W, 8, bits per assembled byte.
- MAX_BYTES, 32, maximum payload bytes per frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- frame_n  input  1  active-low frame; high on the cycle carrying the last payload bit.
- valid_n  input  1  active-low payload-bit qualifier.
- da  output  ADDR_W  captured destination address; held until next frame's address completes.
- da_valid  output  1  one-cycle pulse when the address is complete.
- byte_data  output  DATA_W  assembled byte.
- byte_valid  output  1  one-cycle pulse per byte.
- sop  output  1  qualifies the first byte of a frame.
- eop  output  1  qualifies the last byte of a frame.
- busy  output  1  high while state != IDLE.
- err_proto  output  1  one-cycle pulse on protocol violation.
- err_len  output  1  one-cycle pulse on partial final byte or MAX_BYTES overflow.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all outputs 0, da = 0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately with no error pulse. After release the FSM waits in IDLE; if frame_n is already low, that cycle is treated as a new frame start.
- All outputs are registered. byte_valid, sop, eop, da_valid and the error pulses assert in the cycle after the triggering sample.

States and transitions:
- IDLE: frame_n==0 → da[0] <= din, addr_cnt <= 1, go to ADDR. valid_n is ignored.
- ADDR: da[addr_cnt] <= din each cycle.
  - After bit ADDR_W-1 is captured → da_valid pulse, go to PAD, pad_cnt <= 0.
  - frame_n==1 in ADDR → err_proto, go to IDLE.
- PAD: count PAD_CYCLES cycles; din is ignored.
  - frame_n==1 → err_proto, go to IDLE.
  - valid_n==0 → err_proto, go to DROP.
  - pad_cnt == PAD_CYCLES-1 → go to DATA, bit_cnt <= 0, byte_cnt <= 0, first <= 1.
- DATA, when valid_n==0: shift_reg[bit_cnt] <= din, bit_cnt++.
  - When bit_cnt == DATA_W-1, emit the byte (sop = first), clear first, increment byte_cnt, wrap bit_cnt to 0.
- DATA, when valid_n==1: bubble; hold all state.
- DATA, when frame_n==1 && valid_n==0 (last bit):
  - Completed byte → emit with eop=1, go to IDLE.
  - Otherwise → err_len, nothing emitted, go to IDLE.
- DATA, when frame_n==1 && valid_n==1: err_proto, go to IDLE. An already emitted byte is not retracted and no eop is sent.
- DATA overflow: emitting byte MAX_BYTES+1 → err_len instead of byte_valid, go to DROP.
- DROP: wait for frame_n==1, then go to IDLE.

Edge cases:
- A one-byte frame asserts sop and eop on the same byte.
- Back-to-back frames are legal. frame_n low in the cycle after the last bit starts a new frame from IDLE with no idle gap.
- A zero-payload frame (frame_n high during PAD) is err_proto.
- Counter widths: $clog2 of each limit, plus 1 for byte_cnt so that MAX_BYTES+1 is representable.

Decomposition:
- Package router_pkg holds:
  - typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} rx_state_e;
  - localparams ADDR_W=4, DATA_W=8, PAD_CYCLES=5, NUM_PORTS=16;
  - typedef logic [ADDR_W-1:0] da_t.
- Sub-module router_in_shift (DATA_W shift/assemble register with bit counter and full flag) is natural. It is instantiated once.
- The FSM and error logic stay in the top.

Test Plan:
- Address 4'hA (bits 0,1,0,1), 5 pad cycles, payload byte 8'hC3 LSB first → da_valid with da=4'hA; one byte_valid with byte_data=8'hC3, sop=1, eop=1.
- Address 4'h3, payload 8'h01,8'hFF,8'h5A with two valid_n bubbles inside byte 2 → three bytes in order; sop only on 8'h01, eop only on 8'h5A; bubbles add cycles but no corruption.
- Two frames back-to-back: addr 4'h1/byte 8'h11, then addr 4'hF/byte 8'hEE, frame_n low again the cycle after the first ends → both decoded, da updates to 4'hF, no errors.
- Frame ending after 5 payload bits → err_len pulse, no byte_valid, busy drops next cycle; the following valid frame decodes normally.
- valid_n=0 in pad cycle 3 → err_proto, DROP until frame_n high, no da-related byte output; MAX_BYTES+1 bytes → 32 bytes emitted, then err_len, no eop.
- rst_n low mid-byte in DATA (asynchronous, between edges) → all outputs 0 immediately, no error pulse; after release a fresh frame with addr 4'h7/byte 8'h80 decodes correctly.
